// File: rtl/fxp_sqrt_pipe.sv
// Fully pipelined signed fixed-point square root: out = sign(in)*sqrt(|in|).
// One root bit per stage (restoring digit-by-digit), then round, saturate and re-sign.
module fxp_sqrt_pipe #(
    parameter int unsigned WII   = 8,
    parameter int unsigned WIF   = 8,
    parameter int unsigned WOI   = 8,
    parameter int unsigned WOF   = 8,
    parameter int unsigned ROUND = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WII+WIF-1:0] in,
    output logic [WOI+WOF-1:0] out,
    output logic               overflow
);
    localparam int unsigned WI   = WII + WIF;
    localparam int unsigned WO   = WOI + WOF;
    localparam int unsigned RI   = (WII + 1) / 2;
    localparam int unsigned N    = RI + WOF + 1;
    localparam int unsigned RADW = 2 * N;
    localparam int unsigned RW   = N + 3;
    localparam int unsigned CW   = (N > WO) ? N : WO;
    localparam int          SH   = 2 * int'(WOF) + 2 - int'(WIF);
    localparam logic [CW-1:0] MAX_MAG = CW'({(WO-1){1'b1}});

    logic          s0_d, s0_q;
    logic [WI-1:0] m0_d, m0_q;

    // Stage 0: split into sign and unsigned magnitude (most negative code needs no wrap)
    always_comb begin
        s0_d = in[WI-1];
        m0_d = s0_d ? WI'(-in) : in;
    end

    // Align the magnitude so the root carries WOF+1 fractional bits
    logic [RADW-1:0] rad0;
    if (SH >= 0) begin : g_shl
        always_comb rad0 = RADW'(m0_q) << SH;
    end else begin : g_shr
        always_comb rad0 = RADW'(m0_q >> (-SH));
    end

    // Index j holds the registers of root stage j+1
    logic [RW-1:0]   rem_i  [0:N-1];
    logic [N-1:0]    root_i [0:N-1];
    logic [RADW-1:0] rad_i  [0:N-1];
    logic            sgn_i  [0:N-1];
    logic [RW-1:0]   rem_d  [0:N-1];
    logic [RW-1:0]   rem_q  [0:N-1];
    logic [N-1:0]    root_d [0:N-1];
    logic [N-1:0]    root_q [0:N-1];
    logic [RADW-1:0] rad_d  [0:N-1];
    logic [RADW-1:0] rad_q  [0:N-1];
    logic            sgn_d  [0:N-1];
    logic            sgn_q  [0:N-1];

    always_comb begin : p_root
        logic [RW-1:0] cand;
        logic [RW-1:0] trial;
        cand  = '0;
        trial = '0;
        rem_i[0]  = '0;
        root_i[0] = '0;
        rad_i[0]  = rad0;
        sgn_i[0]  = s0_q;
        for (int j = 1; j < int'(N); j++) begin
            rem_i[j]  = rem_q[j-1];
            root_i[j] = root_q[j-1];
            rad_i[j]  = rad_q[j-1];
            sgn_i[j]  = sgn_q[j-1];
        end
        for (int j = 0; j < int'(N); j++) begin
            // Bring down the next two radicand bits, try subtracting 4*root+1
            cand  = RW'({rem_i[j], rad_i[j][RADW-1 -: 2]});
            trial = RW'({root_i[j], 2'b01});
            rad_d[j] = rad_i[j] << 2;
            sgn_d[j] = sgn_i[j];
            if (cand >= trial) begin
                rem_d[j]  = cand - trial;
                root_d[j] = N'({root_i[j], 1'b1});
            end else begin
                rem_d[j]  = cand;
                root_d[j] = N'({root_i[j], 1'b0});
            end
        end
    end

    logic [N-1:0]  r_c;
    logic [N-1:0]  q_c;
    logic [CW-1:0] mag_c;
    logic [WO-1:0] mag_o;
    logic [WO-1:0] out_d, out_q;
    logic          ovf_d, ovf_q;

    // Final stage: drop the guard bit (optionally rounding), saturate, apply sign
    always_comb begin
        ovf_d = 1'b0;
        r_c   = root_q[N-1];
        q_c   = N'(r_c >> 1) + N'(r_c[0] & (ROUND != 0));
        mag_c = CW'(q_c);
        if (mag_c > MAX_MAG) begin
            mag_c = MAX_MAG;
            ovf_d = 1'b1;
        end
        mag_o = WO'(mag_c);
        out_d = sgn_q[N-1] ? WO'(-mag_o) : mag_o;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_q  <= 1'b0;
            m0_q  <= '0;
            out_q <= '0;
            ovf_q <= 1'b0;
            for (int j = 0; j < int'(N); j++) begin
                rem_q[j]  <= '0;
                root_q[j] <= '0;
                rad_q[j]  <= '0;
                sgn_q[j]  <= 1'b0;
            end
        end else begin
            s0_q  <= s0_d;
            m0_q  <= m0_d;
            out_q <= out_d;
            ovf_q <= ovf_d;
            for (int j = 0; j < int'(N); j++) begin
                rem_q[j]  <= rem_d[j];
                root_q[j] <= root_d[j];
                rad_q[j]  <= rad_d[j];
                sgn_q[j]  <= sgn_d[j];
            end
        end
    end

    assign out      = out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_fxp_sqrt_pipe.sv
// Bench for fxp_sqrt_pipe: three instances (round, truncate, narrow output) against an
// arithmetic reference, with directed constants, a random stream and a mid-stream reset.
module tb_fxp_sqrt_pipe;
    localparam int unsigned WII   = 9;
    localparam int unsigned WIF   = 10;
    localparam int unsigned WOI   = 9;
    localparam int unsigned WOF   = 10;
    localparam int unsigned WOI_S = 3;
    localparam int unsigned WI    = WII + WIF;
    localparam int unsigned WO    = WOI + WOF;
    localparam int unsigned WOS   = WOI_S + WOF;
    localparam int          L     = 18;
    localparam int          SH    = 12;

    typedef struct {
        logic [WI-1:0] x;
        bit            k;
        longint        ea;
        longint        eb;
        longint        ec;
        bit            oc;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [WI-1:0]  din;
    logic [WO-1:0]  out_a, out_b;
    logic [WOS-1:0] out_c;
    logic           ovf_a, ovf_b, ovf_c;
    int             n_vec  = 0;
    int             n_fail = 0;
    vec_t           hist[$];

    always #5 clk = ~clk;

    fxp_sqrt_pipe #(.WII(WII), .WIF(WIF), .WOI(WOI), .WOF(WOF), .ROUND(1)) dut_a (
        .clk(clk), .rst(rst), .in(din), .out(out_a), .overflow(ovf_a));
    fxp_sqrt_pipe #(.WII(WII), .WIF(WIF), .WOI(WOI), .WOF(WOF), .ROUND(0)) dut_b (
        .clk(clk), .rst(rst), .in(din), .out(out_b), .overflow(ovf_b));
    fxp_sqrt_pipe #(.WII(WII), .WIF(WIF), .WOI(WOI_S), .WOF(WOF), .ROUND(1)) dut_c (
        .clk(clk), .rst(rst), .in(din), .out(out_c), .overflow(ovf_c));

    function automatic longint isqrt(input longint v);
        longint lo, hi, mid;
        lo = 0;
        hi = longint'(1) << 20;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    function automatic void model(input logic [WI-1:0] x, input int unsigned woi, input bit rnd,
                                  output longint val, output bit ovf);
        longint v, m, r, q, mx;
        v   = longint'($signed(x));
        m   = (v < 0) ? -v : v;
        r   = isqrt(m * (longint'(1) << SH));
        q   = r / 2 + ((rnd && (r % 2 == 1)) ? 1 : 0);
        mx  = (longint'(1) << (woi + WOF - 1)) - 1;
        ovf = (q > mx);
        if (ovf) q = mx;
        val = (v < 0) ? -q : q;
    endfunction

    function automatic vec_t mk(input logic [WI-1:0] x, input bit k, input longint ea,
                                input longint eb, input longint ec, input bit oc);
        vec_t v;
        v.x = x; v.k = k; v.ea = ea; v.eb = eb; v.ec = ec; v.oc = oc;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [WI-1:0] x, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s in=0x%05h: observed %0d expected %0d", tag, x, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out_r1"}, din, longint'($signed(out_a)), 0);
        chk({tag, "_out_r0"}, din, longint'($signed(out_b)), 0);
        chk({tag, "_out_sat"}, din, longint'($signed(out_c)), 0);
        chk({tag, "_ovf_r1"}, din, longint'(ovf_a), 0);
        chk({tag, "_ovf_r0"}, din, longint'(ovf_b), 0);
        chk({tag, "_ovf_sat"}, din, longint'(ovf_c), 0);
    endtask

    // Apply one sample, then check whatever the pipe should present L edges after its entry
    task automatic tick(input vec_t v);
        longint va, vb, vc;
        bit     oa, ob, oc;
        vec_t   e;
        din = v.x;
        @(posedge clk);
        #1;
        hist.push_back(v);
        if (hist.size() > L) hist.delete(0);
        if (hist.size() < L) begin
            check_zero("fill");
        end else begin
            e = hist[0];
            model(e.x, WOI, 1'b1, va, oa);
            model(e.x, WOI, 1'b0, vb, ob);
            model(e.x, WOI_S, 1'b1, vc, oc);
            chk("out_r1", e.x, longint'($signed(out_a)), va);
            chk("ovf_r1", e.x, longint'(ovf_a), longint'(oa));
            chk("out_r0", e.x, longint'($signed(out_b)), vb);
            chk("ovf_r0", e.x, longint'(ovf_b), longint'(ob));
            chk("out_sat", e.x, longint'($signed(out_c)), vc);
            chk("ovf_sat", e.x, longint'(ovf_c), longint'(oc));
            if (e.k) begin
                chk("dir_r1", e.x, longint'($signed(out_a)), e.ea);
                chk("dir_r1_ovf", e.x, longint'(ovf_a), 0);
                chk("dir_r0", e.x, longint'($signed(out_b)), e.eb);
                chk("dir_sat", e.x, longint'($signed(out_c)), e.ec);
                chk("dir_sat_ovf", e.x, longint'(ovf_c), longint'(e.oc));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        din = '0;
        #2 rst = 1'b0;
        repeat (4) begin
            din = WI'($urandom);
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        rst = 1'b1;
        hist.delete();

        tick(mk(19'h01000, 1'b1,   2048,   2048,  2048, 1'b0));
        tick(mk(19'h00005, 1'b1,     72,     71,    72, 1'b0));
        tick(mk(19'h00800, 1'b1,   1448,   1448,  1448, 1'b0));
        tick(mk(19'h00000, 1'b1,      0,      0,     0, 1'b0));
        tick(mk(19'h7F000, 1'b1,  -2048,  -2048, -2048, 1'b0));
        tick(mk(19'h40000, 1'b1, -16384, -16384, -4095, 1'b1));
        tick(mk(19'h06400, 1'b1,   5120,   5120,  4095, 1'b1));
        tick(mk(19'h79C00, 1'b1,  -5120,  -5120, -4095, 1'b1));
        tick(mk(19'h02400, 1'b1,   3072,   3072,  3072, 1'b0));
        tick(mk(19'h3FFFF, 1'b0, 0, 0, 0, 1'b0));
        tick(mk(19'h7FFFF, 1'b0, 0, 0, 0, 1'b0));
        repeat (L) tick(mk(WI'(0), 1'b0, 0, 0, 0, 1'b0));

        for (int i = 0; i < 40; i++) begin
            tick(mk(WI'($urandom), 1'b0, 0, 0, 0, 1'b0));
            if (i == 24) begin
                rst = 1'b0;
                #1;
                check_zero("async_rst");
                hist.delete();
                repeat (2) begin
                    din = WI'($urandom);
                    @(posedge clk);
                    #1;
                    check_zero("rst_mid");
                end
                rst = 1'b1;
            end
        end
        repeat (L) tick(mk(WI'($urandom), 1'b0, 0, 0, 0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
